// File: rtl/servo_pwm_generator.sv
// Framed servo PWM: on_time is sampled once per frame and emitted as a registered high pulse.
// Optional SLEW_LIMIT_EN macro ramps the applied on-time by at most SLEW per frame.
module servo_pwm_generator #(
  parameter int unsigned W      = 28,
  parameter int unsigned PERIOD = 2_000_000,
  parameter int unsigned MIN_ON = 100_000,
  parameter int unsigned MAX_ON = 250_000,
  parameter int unsigned SLEW   = 5_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [W-1:0] on_time,
  output logic         pwm_out,
  output logic         frame_start,
  output logic [W-1:0] active_on_time,
  output logic         clamped
);

  // state  | meaning
  // S_OFF  | no pulse this frame (disabled or zero on-time)
  // S_HIGH | pulse in progress, cnt < active_on_time
  // S_LOW  | pulse finished, waiting for frame wrap
  typedef enum logic [1:0] {S_OFF, S_HIGH, S_LOW} state_t;

  localparam logic [W-1:0] PERIOD_M1 = W'(PERIOD - 1);
  localparam logic [W-1:0] MIN_V     = W'(MIN_ON);
  localparam logic [W-1:0] MAX_V     = W'(MAX_ON);
  localparam logic [W-1:0] SLEW_V    = W'(SLEW);

  if (MIN_ON == 0 || MIN_ON > MAX_ON || MAX_ON >= PERIOD || SLEW == 0 ||
      64'(PERIOD) > (64'(1) << W)) begin : g_bad_cfg
    $error("servo_pwm_generator: illegal PERIOD/MIN_ON/MAX_ON/SLEW/W combination");
  end

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] active_q, active_d;
  logic         clamped_q, clamped_d;
  logic         started_q, started_d;
  logic         pwm_q, pwm_d;
  logic         frame_start_q, frame_start_d;
  logic [W-1:0] target, next_active;
  logic         range_clip;
  logic         wrap;

  assign wrap = started_q && (cnt_q == PERIOD_M1);

  always_comb begin
    target     = on_time;
    range_clip = 1'b0;
    if (on_time == '0) begin
      target = '0;
    end else if (on_time < MIN_V) begin
      target     = MIN_V;
      range_clip = 1'b1;
    end else if (on_time > MAX_V) begin
      target     = MAX_V;
      range_clip = 1'b1;
    end
  end

`ifdef SLEW_LIMIT_EN
  // Leaving zero jumps straight to MIN_ON; both values are then in range so no underflow.
  always_comb begin
    next_active = target;
    if (target != '0 && active_q == '0) begin
      next_active = MIN_V;
    end else if (target != '0) begin
      if (target > active_q && (target - active_q) > SLEW_V) begin
        next_active = active_q + SLEW_V;
      end else if (target < active_q && (active_q - target) > SLEW_V) begin
        next_active = active_q - SLEW_V;
      end
    end
  end
`else
  assign next_active = target;
`endif

  always_comb begin
    started_d = 1'b1;
    cnt_d     = cnt_q + W'(1);
    if (!started_q || wrap) begin
      cnt_d = '0;
    end
    active_d  = active_q;
    clamped_d = clamped_q;
    if (wrap) begin
      active_d  = next_active;
      clamped_d = range_clip;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (wrap) begin
      state_d = (enable && target != '0) ? S_HIGH : S_OFF;
    end else if (state_q == S_HIGH && cnt_q == active_q - W'(1)) begin
      state_d = S_LOW;
    end
  end

  always_comb begin
    pwm_d         = (state_q == S_HIGH);
    frame_start_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      started_q     <= 1'b0;
      active_q      <= '0;
      clamped_q     <= 1'b0;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      started_q     <= started_d;
      active_q      <= active_d;
      clamped_q     <= clamped_d;
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pwm_out        = pwm_q;
  assign frame_start    = frame_start_q;
  assign active_on_time = active_q;
  assign clamped        = clamped_q;

endmodule

// File: tb/tb_servo_pwm_generator.sv
// Directed bench for servo_pwm_generator with a shortened frame (PERIOD=2000).
module tb_servo_pwm_generator;
  localparam int W      = 28;
  localparam int PERIOD = 2000;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [W-1:0] on_time;
  logic         pwm_out;
  logic         frame_start;
  logic [W-1:0] active_on_time;
  logic         clamped;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  servo_pwm_generator #(
    .W(W), .PERIOD(PERIOD), .MIN_ON(100), .MAX_ON(250), .SLEW(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .on_time(on_time),
    .pwm_out(pwm_out),
    .frame_start(frame_start),
    .active_on_time(active_on_time),
    .clamped(clamped)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_frame_start(input string tag);
    int n = 0;
    while (frame_start !== 1'b1 && n < PERIOD + 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_fs_seen"}, 32'(frame_start), 32'(1));
  endtask

  // Called at the negedge of a cnt==0 cycle; returns at the next frame's cnt==0 negedge.
  task automatic measure_frame(input string tag, input int exp_high, input int exp_act,
                               input logic exp_clamp, input int chg_at, input int chg_on,
                               input logic chg_en);
    int highs    = 0;
    int first    = -1;
    int last     = -1;
    int extra_fs = 0;
    check({tag, "_active"}, 32'(active_on_time), 32'(exp_act));
    check({tag, "_clamped"}, 32'(clamped), 32'(exp_clamp));
    for (int i = 0; i < PERIOD; i++) begin
      if (pwm_out === 1'b1) begin
        highs++;
        if (first < 0) first = i;
        last = i;
      end
      if (i > 0 && frame_start !== 1'b0) extra_fs++;
      if (i == chg_at) begin
        on_time = W'(chg_on);
        enable  = chg_en;
      end
      @(negedge clk);
    end
    check({tag, "_highs"}, 32'(highs), 32'(exp_high));
    check({tag, "_first"}, 32'(first), 32'((exp_high > 0) ? 1 : -1));
    check({tag, "_last"}, 32'(last), 32'((exp_high > 0) ? exp_high : -1));
    check({tag, "_extra_fs"}, 32'(extra_fs), 32'(0));
    check({tag, "_next_fs"}, 32'(frame_start), 32'(1));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    enable  = 1'b1;
    on_time = W'(150);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pwm", 32'(pwm_out), 32'(0));
    check("rst_fs", 32'(frame_start), 32'(0));
    check("rst_active", 32'(active_on_time), 32'(0));
    check("rst_clamped", 32'(clamped), 32'(0));
    rst = 1'b0;
    wait_frame_start("f0");

`ifndef SLEW_LIMIT_EN
    measure_frame("f0_reset",     0,   0,   1'b0, -1, 150, 1'b1);
    measure_frame("f1_150",       150, 150, 1'b0, 75, 200, 1'b1);
    measure_frame("f2_200",       200, 200, 1'b0, 0,  40,  1'b1);
    measure_frame("f3_clampmin",  100, 100, 1'b1, 0,  900, 1'b1);
    measure_frame("f4_clampmax",  250, 250, 1'b1, 0,  0,   1'b1);
    measure_frame("f5_zero",      0,   0,   1'b0, 0,  100, 1'b1);
    measure_frame("f6_min",       100, 100, 1'b0, 0,  250, 1'b1);
    measure_frame("f7_max",       250, 250, 1'b0, 0,  200, 1'b1);
    measure_frame("f8_enfall",    200, 200, 1'b0, 50, 200, 1'b0);
    measure_frame("f9_disabled",  0,   200, 1'b0, 0,  150, 1'b1);

    check("f10_active", 32'(active_on_time), 32'(150));
    repeat (120) @(negedge clk);
    check("f10_pwm_at120", 32'(pwm_out), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pwm", 32'(pwm_out), 32'(0));
    check("midrst_active", 32'(active_on_time), 32'(0));
    check("midrst_fs", 32'(frame_start), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    wait_frame_start("post_rst");
    measure_frame("r0_reset",     0,   0,   1'b0, PERIOD - 1, 180, 1'b1);
    measure_frame("r1_boundary",  180, 180, 1'b0, -1, 180, 1'b1);
`else
    measure_frame("s0_reset",     0,   0,   1'b0, 0, 100, 1'b1);
    measure_frame("s1_min",       100, 100, 1'b0, 0, 200, 1'b1);
    for (int k = 0; k < 6; k++) begin
      measure_frame("s_ramp", (k < 4) ? 120 + 20 * k : 200, (k < 4) ? 120 + 20 * k : 200,
                    1'b0, -1, 200, 1'b1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
